// File: rtl/ls_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ls_pkg : shared types and defaults for the load/store ctrl     |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package ls_pkg;

  localparam int DW   = 32;
  localparam int RAW  = 5;
  localparam int MAW  = 6;
  localparam int IMMW = 16;

  localparam logic OP_LW = 1'b0;
  localparam logic OP_SW = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RDREG = 3'd1,
    S_CALC  = 3'd2,
    S_MEM   = 3'd3,
    S_MWAIT = 3'd4,
    S_WB    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ls_agu.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ls_agu : effective address = base + sext(imm), word index, and |
// |          alignment / range error flag                          |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module ls_agu #(
  parameter int DW   = ls_pkg::DW,
  parameter int MAW  = ls_pkg::MAW,
  parameter int IMMW = ls_pkg::IMMW
) (
  input  logic [DW-1:0]   i_base,
  input  logic [IMMW-1:0] i_imm,
  output logic [MAW-1:0]  o_word,
  output logic            o_err
);

  logic [DW-1:0] w_sext;
  logic [DW-1:0] w_ea;

  always_comb begin
    w_sext = {{(DW-IMMW){i_imm[IMMW-1]}}, i_imm};
    w_ea   = i_base + w_sext;
    o_word = w_ea[MAW+1:2];
    // Anything above the memory window or not word aligned is rejected.
    o_err  = (w_ea[1:0] != 2'b00) || (w_ea[DW-1:MAW+2] != '0);
  end

endmodule
`default_nettype wire

// File: rtl/ls_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------+
// | ls_mem_ctrl : multi-cycle LW/SW controller between register    |
// |               file and synchronous-read data memory            |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module ls_mem_ctrl
  import ls_pkg::*;
#(
  parameter int DW   = ls_pkg::DW,
  parameter int RAW  = ls_pkg::RAW,
  parameter int MAW  = ls_pkg::MAW,
  parameter int IMMW = ls_pkg::IMMW
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic            op,
  input  logic [RAW-1:0]  rs,
  input  logic [RAW-1:0]  rt,
  input  logic [IMMW-1:0] imm,
  output logic            busy,
  output logic            done,
  output logic            addr_err,
  output logic [RAW-1:0]  R_Addr_A,
  output logic [RAW-1:0]  R_Addr_B,
  input  logic [DW-1:0]   R_Data_A,
  input  logic [DW-1:0]   R_Data_B,
  output logic [RAW-1:0]  W_Addr,
  output logic [DW-1:0]   W_Data,
  output logic            Write_reg,
  output logic            wea,
  output logic [MAW-1:0]  addr,
  output logic [DW-1:0]   dina,
  input  logic [DW-1:0]   douta
);

  state_t          r_state, w_next;
  logic            r_op;
  logic [RAW-1:0]  r_rs, r_rt;
  logic [IMMW-1:0] r_imm;
  logic [DW-1:0]   r_a, r_b, r_d;
  logic [MAW-1:0]  r_word;
  logic            r_err;
  logic [MAW-1:0]  w_word;
  logic            w_err;

  ls_agu #(.DW(DW), .MAW(MAW), .IMMW(IMMW)) u_agu (
    .i_base (r_a),
    .i_imm  (r_imm),
    .o_word (w_word),
    .o_err  (w_err)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RDREG;
      S_RDREG: w_next = S_CALC;
      S_CALC:  w_next = w_err ? S_DONE : S_MEM;
      S_MEM:   w_next = (r_op == OP_SW) ? S_DONE : S_MWAIT;
      S_MWAIT: w_next = S_WB;
      S_WB:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_op   <= 1'b0;
      r_rs   <= '0;
      r_rt   <= '0;
      r_imm  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_word <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op  <= op;
          r_rs  <= rs;
          r_rt  <= rt;
          r_imm <= imm;
        end
        S_RDREG: begin
          r_a <= R_Data_A;
          r_b <= R_Data_B;
        end
        S_CALC: begin
          r_word <= w_word;
          r_err  <= w_err;
        end
        S_MWAIT: r_d <= douta;
        default: ;
      endcase
    end
  end

  // Outputs are pure decodes of state and registered data, so a reset
  // edge removes every strobe in the following cycle.
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    addr_err  = 1'b0;
    R_Addr_A  = '0;
    R_Addr_B  = '0;
    W_Addr    = '0;
    W_Data    = '0;
    Write_reg = 1'b0;
    wea       = 1'b0;
    addr      = '0;
    dina      = '0;
    case (r_state)
      S_RDREG: begin
        R_Addr_A = r_rs;
        R_Addr_B = r_rt;
      end
      S_MEM: begin
        addr = r_word;
        if (r_op == OP_SW) begin
          wea  = 1'b1;
          dina = r_b;
        end
      end
      S_MWAIT: addr = r_word;
      S_WB: begin
        W_Addr    = r_rt;
        W_Data    = r_d;
        Write_reg = (r_rt != '0);
      end
      S_DONE: begin
        done     = 1'b1;
        addr_err = r_err;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
